// File: rtl/cpu_axi_master_pkg.sv
// Shared types and AXI constants for the CPU-to-AXI master bridge.
// Bus widths match the system AXI definition.
package axi_master_pkg;

  localparam int AXI_ID_BITS    = 4;
  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXI_DATA_BITS  = 32;
  localparam int AXI_STRB_BITS  = 4;
  localparam int AXI_LEN_BITS   = 4;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;
  localparam int AXI_RESP_BITS  = 2;

  localparam logic [AXI_LEN_BITS-1:0]   LEN_SINGLE = '0;
  localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
  localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP,
    S_DONE
  } master_state_e;

endpackage

// File: rtl/cpu_axi_master.sv
// Single-outstanding AXI4 master: one stalled CPU request becomes
// one single-beat AXI read or write.
module cpu_axi_master
  import axi_master_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0] MASTER_ID = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [3:0]                cpu_web,
  output logic                      cpu_stall,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_err,
  output logic [AXI_ID_BITS-1:0]    awid,
  output logic [AXI_ADDR_BITS-1:0]  awaddr,
  output logic [AXI_LEN_BITS-1:0]   awlen,
  output logic [AXI_SIZE_BITS-1:0]  awsize,
  output logic [AXI_BURST_BITS-1:0] awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [AXI_DATA_BITS-1:0]  wdata,
  output logic [AXI_STRB_BITS-1:0]  wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [AXI_ID_BITS-1:0]    bid,
  input  logic [AXI_RESP_BITS-1:0]  bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AXI_ID_BITS-1:0]    arid,
  output logic [AXI_ADDR_BITS-1:0]  araddr,
  output logic [AXI_LEN_BITS-1:0]   arlen,
  output logic [AXI_SIZE_BITS-1:0]  arsize,
  output logic [AXI_BURST_BITS-1:0] arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_ID_BITS-1:0]    rid,
  input  logic [AXI_DATA_BITS-1:0]  rdata,
  input  logic [AXI_RESP_BITS-1:0]  rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  master_state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  web_q, web_d;
  logic        aw_ok_q, aw_ok_d;
  logic        w_ok_q, w_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        aw_done;
  logic        w_done;

  // IDs are not checked: only one transaction is ever in flight.
  logic        unused_ids;
  assign unused_ids = ^{bid, rid};

  // Handshake signals decode only from flops, never from slave inputs.
  assign arvalid = (state_q == S_RADDR);
  assign rready  = (state_q == S_RDATA);
  assign awvalid = (state_q == S_WADDR) && !aw_ok_q;
  assign wvalid  = (state_q == S_WADDR) && !w_ok_q;
  assign bready  = (state_q == S_WRESP);

  assign arid    = MASTER_ID;
  assign araddr  = addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;

  assign awid    = MASTER_ID;
  assign awaddr  = addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = SIZE_WORD;
  assign awburst = BURST_INCR;

  assign wdata   = wdata_q;
  assign wstrb   = web_q;
  assign wlast   = 1'b1;

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

  assign aw_done = aw_ok_q || (awvalid && awready);
  assign w_done  = w_ok_q || (wvalid && wready);

  // Next-state, request capture and CPU stall.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    web_d     = web_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cpu_stall = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cpu_stall = cpu_req;
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          web_d   = cpu_web;
          err_d   = 1'b0;
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = cpu_we ? S_WADDR : S_RADDR;
        end
      end
      S_RADDR: begin
        if (arready) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rvalid && rlast) begin
          rdata_d = rdata;
          err_d   = (rresp != RESP_OKAY);
          state_d = S_DONE;
        end
      end
      S_WADDR: begin
        aw_ok_d = aw_done;
        w_ok_d  = w_done;
        if (aw_done && w_done) begin
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          err_d   = (bresp != RESP_OKAY);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cpu_stall = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, write-channel done flags and CPU response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      web_q   <= '0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      web_q   <= web_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Scoreboard bench for cpu_axi_master with a configurable AXI slave.
// Directed transactions; a monitor checks CPU responses and bus fields.
module tb_cpu_axi_master;
  import axi_master_pkg::*;

  localparam logic [AXI_ID_BITS-1:0] MID = 4'd3;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_web;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  cpu_axi_master #(.MASTER_ID(MID)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_web(cpu_web), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] rd;
    logic        err;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_strb;

  int          ar_delay = 0;
  int          aw_delay = 0;
  int          w_delay = 0;
  int          r_delay = 0;
  int          r_extra = 0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00;
  logic [1:0]  b_resp = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Slave model: readiness after programmable waits, R/B responses.
  initial begin : slave
    int  ar_wait, aw_wait, w_wait, r_cnt, r_left;
    bit  r_pend, aw_got, w_got;
    bit  ar_hs, aw_hs, w_hs, r_hs, b_hs;
    ar_wait = 0; aw_wait = 0; w_wait = 0; r_cnt = 0; r_left = 0;
    r_pend = 0; aw_got = 0; w_got = 0;
    arready = 0; awready = 0; wready = 0;
    bvalid = 0; bresp = 0; bid = MID;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = MID;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      r_hs  = rvalid && rready;
      b_hs  = bvalid && bready;
      @(posedge clk);
      #1;
      if (!rst) begin
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        r_pend = 0; aw_got = 0; w_got = 0;
        arready = 0; awready = 0; wready = 0;
        bvalid = 0; rvalid = 0; rlast = 0;
      end else begin
        if (ar_hs) begin
          r_pend = 1; r_cnt = r_delay; r_left = r_extra;
        end
        if (arvalid && ar_wait == ar_delay) begin
          arready = 1; ar_wait = 0;
        end else begin
          arready = 0;
          if (arvalid) ar_wait++;
        end
        if (r_hs) begin
          if (rlast) r_pend = 0;
          else r_left--;
        end
        if (r_pend && r_cnt > 0) begin
          r_cnt--; rvalid = 0; rlast = 0;
        end else if (r_pend) begin
          rvalid = 1;
          rlast  = (r_left == 0);
          rdata  = (r_left == 0) ? r_data : 32'hBAD0_0000 + r_left;
          rresp  = (r_left == 0) ? r_resp : 2'b00;
        end else begin
          rvalid = 0; rlast = 0;
        end
        if (awvalid && aw_wait == aw_delay) begin
          awready = 1; aw_wait = 0;
        end else begin
          awready = 0;
          if (awvalid) aw_wait++;
        end
        if (wvalid && w_wait == w_delay) begin
          wready = 1; w_wait = 0;
        end else begin
          wready = 0;
          if (wvalid) w_wait++;
        end
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (b_hs) bvalid = 0;
        if (aw_got && w_got) begin
          bvalid = 1; bresp = b_resp; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  // Monitor: CPU responses against the scoreboard, bus payloads and holds.
  initial begin : monitor
    bit p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        if (cpu_req && !cpu_stall) begin
          done_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata %h err %b expected none",
                     cpu_rdata, cpu_err);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_read) chk("cpu_rdata", cpu_rdata, mon_e.rd);
            chk("cpu_err", {31'd0, cpu_err}, {31'd0, mon_e.err});
            chk("latency", cyc - mon_e.start, mon_e.lat);
          end
        end
        if (p_arv && !p_arr) chk("ar_held", {31'd0, arvalid}, 32'd1);
        if (p_awv && !p_awr) chk("aw_held", {31'd0, awvalid}, 32'd1);
        if (p_wv && !p_wr) chk("w_held", {31'd0, wvalid}, 32'd1);
        if (arvalid) begin
          chk("araddr", araddr, exp_addr);
          chk("ar_fields", {19'd0, arid, arlen, arsize, arburst},
              {19'd0, MID, 4'd0, 3'b010, 2'b01});
        end
        if (awvalid) begin
          chk("awaddr", awaddr, exp_addr);
          chk("aw_fields", {19'd0, awid, awlen, awsize, awburst},
              {19'd0, MID, 4'd0, 3'b010, 2'b01});
        end
        if (wvalid) begin
          chk("wdata", wdata, exp_wdata);
          chk("wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, exp_strb, 1'b1});
        end
        p_arv = arvalid; p_arr = arready;
        p_awv = awvalid; p_awr = awready;
        p_wv  = wvalid;  p_wr  = wready;
      end
    end
  end

  // Called #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] web,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit expect_resp);
    exp_t e;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_web = web;
    cpu_req = 1'b1;
    exp_addr = a; exp_wdata = d; exp_strb = web;
    if (expect_resp) begin
      e.is_read = !we; e.rd = exp_rd; e.err = exp_err;
      e.start = cyc; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d responses expected %0d",
               name, done_cnt, target);
    end
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_web = 4'hF;
    exp_addr = '0; exp_wdata = '0; exp_strb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_handshakes", {27'd0, arvalid, awvalid, wvalid, rready, bready},
        32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err", {31'd0, cpu_err}, 32'd0);
    cpu_req = 1'b1;
    #1;
    chk("stall_follows_req_hi", {31'd0, cpu_stall}, 32'd1);
    cpu_req = 1'b0;
    #1;
    chk("stall_follows_req_lo", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    r_data = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3, 1);
    wait_done(1, "read_zero_wait");
    cpu_req = 1'b0;

    aw_delay = 1; w_delay = 3;
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b1100, 32'h0, 1'b0, 6, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("aw_dropped", {31'd0, awvalid}, 32'd0);
    chk("w_still_valid", {31'd0, wvalid}, 32'd1);
    wait_done(2, "write_slow_w");
    cpu_req = 1'b0;
    aw_delay = 0; w_delay = 0;

    ar_delay = 5; r_data = 32'h0BAD_F00D;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 8, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("ar_wait_stall", {30'd0, cpu_stall, arvalid}, 32'd3);
    wait_done(3, "read_slow_ar");
    cpu_req = 1'b0;
    ar_delay = 0;

    b_resp = 2'b10;
    issue(1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 4'b0000, 32'h0, 1'b1, 3, 1);
    wait_done(4, "write_slverr");
    cpu_req = 1'b0;
    b_resp = 2'b00;
    r_data = 32'h7777_8888;
    issue(1'b0, 32'h0000_0034, 32'h0, 4'hF, 32'h7777_8888, 1'b0, 3, 1);
    wait_done(5, "read_after_err");
    cpu_req = 1'b0;

    r_data = 32'h1111_2222;
    issue(1'b0, 32'h0000_0044, 32'h0, 4'hF, 32'h1111_2222, 1'b0, 3, 1);
    wait_done(6, "b2b_first");
    chk("b2b_idle_gap", {30'd0, arvalid, awvalid}, 32'd0);
    issue(1'b1, 32'h0000_0048, 32'hCAFE_BABE, 4'b0101, 32'h0, 1'b0, 3, 1);
    @(posedge clk);
    #1;
    chk("b2b_aw_issue", {30'd0, awvalid, wvalid}, 32'd3);
    wait_done(7, "b2b_second");
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_dup", {29'd0, arvalid, awvalid, cpu_stall}, 32'd0);

    r_delay = 4; r_data = 32'h5555_AAAA;
    issue(1'b0, 32'h0000_0050, 32'h0, 4'hF, 32'h0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("in_rdata", {31'd0, rready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_rready", {28'd0, rready, arvalid, awvalid, wvalid}, 32'd0);
    cpu_req = 1'b0;
    #1;
    chk("rst_idle", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    r_delay = 0;
    @(posedge clk);
    #1;
    r_data = 32'h600D_CAFE;
    issue(1'b0, 32'h0000_0054, 32'h0, 4'hF, 32'h600D_CAFE, 1'b0, 3, 1);
    wait_done(8, "read_after_rst");
    cpu_req = 1'b0;

    r_extra = 2; r_data = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0060, 32'h0, 4'hF, 32'hCAFE_0001, 1'b0, 5, 1);
    wait_done(9, "read_multi_beat");
    cpu_req = 1'b0;
    r_extra = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
